// File: rtl/alu_pkg.sv
// Shared opcode, compare-flag and FSM encodings for the execute-stage ALU.
// ALU_SIGNED_EN enables the OP_CMPS/OP_ASR opcodes in alu_pipe.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_LD   = 4'd1;
  localparam logic [3:0] OP_ST   = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_CMP  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_LSL  = 4'd10;
  localparam logic [3:0] OP_LSR  = 4'd11;
  localparam logic [3:0] OP_CMPS = 4'd12;
  localparam logic [3:0] OP_ASR  = 4'd13;

  localparam logic [1:0] CMP_LT = 2'd0;
  localparam logic [1:0] CMP_EQ = 2'd1;
  localparam logic [1:0] CMP_GT = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  function automatic logic [1:0] cmp_code(input logic lt, input logic eq);
    return eq ? CMP_EQ : (lt ? CMP_LT : CMP_GT);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Request/response bundle between an issue slot and its alu_pipe instance.
// The slave side is the ALU; the master side is the producer/consumer.
interface alu_pipe_if #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [IMM_W-1:0] imm;
  logic             use_imm;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [1:0]       cmp_flag;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, op, op1, op2, imm, use_imm, out_ready,
    input  in_ready, out_valid, result, cmp_flag, illegal, busy
  );

  modport slave (
    input  in_valid, op, op1, op2, imm, use_imm, out_ready,
    output in_ready, out_valid, result, cmp_flag, illegal, busy
  );
endinterface

// File: rtl/alu_mul_pipe.sv
// MUL datapath: MUL_LAT-1 product stages ahead of the top-level result register.
// With MUL_LAT=1 the product is purely combinational and done is tied high.
module alu_mul_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             take,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  logic [WIDTH-1:0] prod_c;
  assign prod_c = a * b;

  generate
    if (MUL_LAT == 1) begin : g_comb
      logic unused_comb;
      assign unused_comb = ^{clk, rst_n, start, take};
      assign product = prod_c;
      assign done    = 1'b1;
    end else begin : g_pipe
      localparam int STAGES = MUL_LAT - 1;

      logic [WIDTH-1:0]  stage_q [STAGES];
      logic [STAGES-1:0] vld_q;
      logic [STAGES-1:0] vld_d;
      logic [STAGES:0]   vld_chain;

      assign vld_chain = {vld_q, start};

      // the last valid bit is sticky so a stalled product stays flagged until taken
      always_comb begin
        vld_d           = vld_chain[STAGES-1:0];
        vld_d[STAGES-1] = vld_chain[STAGES-1] | (vld_q[STAGES-1] & ~take);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
        end else begin
          vld_q <= vld_d;
          if (start) stage_q[0] <= prod_c;
          for (int k = 1; k < STAGES; k++) stage_q[k] <= stage_q[k-1];
        end
      end

      assign product = stage_q[STAGES-1];
      assign done    = vld_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/alu_pipe.sv
// Pipelined execute-stage ALU: valid/ready in, registered result out, multi-cycle MUL.
// Define ALU_SIGNED_EN to add CMPS (opcode 12) and ASR (opcode 13).
//
// state   | meaning
// ST_IDLE | accepting ops; single-cycle results load straight into the output register
// ST_MUL  | MUL in flight; counter runs down, then waits for a free output slot
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int IMM_W   = 5,
  parameter int MUL_LAT = 2
) (
  input logic      clk,
  input logic      rst_n,
  alu_pipe_if.slave bus
);

  localparam bit   MUL_MULTI = (MUL_LAT > 1);
  localparam int   CNT_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  alu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_opnd, b_opnd, res_c, mul_prod, result_q;
  logic [1:0]       cmp_c, cmp_q;
  logic             ill_c, out_valid_q, illegal_q;
  logic             slot_free, accept, mul_start, mul_take, mul_done, load_single;

  assign a_opnd      = bus.op1;
  assign b_opnd      = bus.use_imm ? WIDTH'(bus.imm) : bus.op2;
  assign slot_free   = !out_valid_q || bus.out_ready;
  assign accept      = bus.in_valid && bus.in_ready;
  assign mul_start   = accept && (bus.op == OP_MUL) && MUL_MULTI;
  assign load_single = accept && !mul_start;

  alu_mul_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .take    (mul_take),
    .a       (a_opnd),
    .b       (b_opnd),
    .product (mul_prod),
    .done    (mul_done)
  );

`ifdef ALU_SIGNED_EN
  logic [WIDTH-1:0] asr_c;
  assign asr_c = $signed(a_opnd) >>> b_opnd;
`endif

  always_comb begin
    res_c = '0;
    ill_c = 1'b0;
    cmp_c = cmp_q;
    case (bus.op)
      OP_ADD, OP_LD, OP_ST: res_c = a_opnd + b_opnd;
      OP_SUB:  res_c = a_opnd - b_opnd;
      OP_MUL:  res_c = mul_prod;
      OP_CMP: begin
        res_c = WIDTH'(a_opnd == b_opnd);
        cmp_c = cmp_code(a_opnd < b_opnd, a_opnd == b_opnd);
      end
      OP_MOV:  res_c = b_opnd;
      OP_OR:   res_c = a_opnd | b_opnd;
      OP_AND:  res_c = a_opnd & b_opnd;
      OP_NOT:  res_c = ~a_opnd;
      OP_LSL:  res_c = (b_opnd >= SHIFT_LIM) ? '0 : (a_opnd << b_opnd);
      OP_LSR:  res_c = (b_opnd >= SHIFT_LIM) ? '0 : (a_opnd >> b_opnd);
`ifdef ALU_SIGNED_EN
      OP_CMPS: begin
        res_c = WIDTH'(a_opnd == b_opnd);
        cmp_c = cmp_code($signed(a_opnd) < $signed(b_opnd), a_opnd == b_opnd);
      end
      OP_ASR:  res_c = (b_opnd >= SHIFT_LIM) ? {WIDTH{a_opnd[WIDTH-1]}} : asr_c;
`endif
      default: ill_c = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_take     = 1'b0;
    bus.in_ready = (state_q == ST_IDLE) && slot_free;
    bus.busy     = (state_q == ST_MUL);
    case (state_q)
      ST_IDLE: begin
        if (mul_start) begin
          state_d = ST_MUL;
          cnt_d   = CNT_W'(MUL_LAT - 1);
        end
      end
      ST_MUL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (mul_done && slot_free) begin
          mul_take = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      cmp_q       <= CMP_LT;
    end else if (load_single) begin
      out_valid_q <= 1'b1;
      result_q    <= res_c;
      illegal_q   <= ill_c;
      cmp_q       <= cmp_c;
    end else if (mul_take) begin
      out_valid_q <= 1'b1;
      result_q    <= mul_prod;
      illegal_q   <= 1'b0;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.illegal   = illegal_q;
  assign bus.cmp_flag  = cmp_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: expected beats are queued at issue and checked by a monitor.
// Define ALU_SIGNED_EN to exercise CMPS/ASR instead of their illegal-opcode behaviour.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int WIDTH = 16;
  localparam int IMM_W = 5;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ill;
    logic [1:0]       cmp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(WIDTH), .IMM_W(IMM_W)) bus ();

  alu_pipe #(.WIDTH(WIDTH), .IMM_W(IMM_W), .MUL_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [IMM_W-1:0] im, input logic ui,
                       input logic [WIDTH-1:0] er, input logic ei, input logic [1:0] ec,
                       input bit push = 1'b1);
    int   waited;
    bit   ok;
    exp_t e;
    waited = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.op1 = a;
    bus.op2 = b;
    bus.imm = im;
    bus.use_imm = ui;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL issue_timeout: op %0d never accepted within 50 cycles", op);
    end else if (push) begin
      e.res = er;
      e.ill = ei;
      e.cmp = ec;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: result 0x%0h with nothing expected", bus.result);
        end else begin
          e = sb_q.pop_front();
          check("beat_result", 32'(bus.result), 32'(e.res));
          check("beat_illegal", 32'(bus.illegal), 32'(e.ill));
          check("beat_cmp_flag", 32'(bus.cmp_flag), 32'(e.cmp));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.op = OP_ADD;
    bus.op1 = '0;
    bus.op2 = '0;
    bus.imm = '0;
    bus.use_imm = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_cmp_flag", 32'(bus.cmp_flag), 0);
    check("rst_illegal", 32'(bus.illegal), 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 1);

    // ADD wrap, single-cycle latency
    issue(OP_ADD, 16'hFFFF, 16'h0002, 5'd0, 1'b0, 16'h0001, 1'b0, CMP_LT);
    check("add_out_valid", 32'(bus.out_valid), 1);
    check("add_result", 32'(bus.result), 32'h0001);
    check("add_cmp_flag", 32'(bus.cmp_flag), 32'(CMP_LT));

    // compares and flag hold
    issue(OP_CMP, 16'd7, 16'd0, 5'd9, 1'b1, 16'd0, 1'b0, CMP_LT);
    issue(OP_CMP, 16'd9, 16'd0, 5'd9, 1'b1, 16'd1, 1'b0, CMP_EQ);
    check("cmp_eq_flag", 32'(bus.cmp_flag), 32'(CMP_EQ));
    issue(OP_ADD, 16'd1, 16'd2, 5'd0, 1'b0, 16'd3, 1'b0, CMP_EQ);
    check("cmp_hold_after_add", 32'(bus.cmp_flag), 32'(CMP_EQ));
    issue(OP_CMP, 16'h000A, 16'h0003, 5'd0, 1'b0, 16'd0, 1'b0, CMP_GT);
    issue(4'd14, 16'h1234, 16'h5678, 5'd0, 1'b0, 16'd0, 1'b1, CMP_GT);
    check("illegal14_flag", 32'(bus.illegal), 1);

    // MUL latency and busy window
    issue(OP_MUL, 16'h0123, 16'h0010, 5'd0, 1'b0, 16'h1230, 1'b0, CMP_GT);
    check("mul_t0_in_ready", 32'(bus.in_ready), 0);
    check("mul_t0_busy", 32'(bus.busy), 1);
    check("mul_t0_out_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    check("mul_t1_out_valid", 32'(bus.out_valid), 0);
    check("mul_t1_busy", 32'(bus.busy), 1);
    @(posedge clk);
    #1;
    check("mul_t2_out_valid", 32'(bus.out_valid), 1);
    check("mul_t2_result", 32'(bus.result), 32'h1230);
    check("mul_t2_busy", 32'(bus.busy), 0);
    check("mul_t2_in_ready", 32'(bus.in_ready), 1);
    issue(OP_MUL, 16'h1234, 16'h0100, 5'd0, 1'b0, 16'h3400, 1'b0, CMP_GT);

    // back-pressure on a back-to-back ADD stream
    issue(OP_ADD, 16'd1, 16'd1, 5'd0, 1'b0, 16'd2, 1'b0, CMP_GT);
    bus.out_ready = 1'b0;
    fork
      begin
        issue(OP_ADD, 16'd3, 16'd4, 5'd0, 1'b0, 16'd7, 1'b0, CMP_GT);
        issue(OP_ADD, 16'h0010, 16'h0020, 5'd0, 1'b0, 16'h0030, 1'b0, CMP_GT);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          @(posedge clk);
          #1;
          check("stall_result_held", 32'(bus.result), 32'd2);
          check("stall_out_valid", 32'(bus.out_valid), 1);
          check("stall_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
      end
    join

    // remaining opcodes and shift boundaries
    issue(OP_SUB, 16'h0000, 16'h0001, 5'd0, 1'b0, 16'hFFFF, 1'b0, CMP_GT);
    issue(OP_LD,  16'h0100, 16'h7777, 5'd4, 1'b1, 16'h0104, 1'b0, CMP_GT);
    issue(OP_ST,  16'h0010, 16'h0020, 5'd0, 1'b0, 16'h0030, 1'b0, CMP_GT);
    issue(OP_MOV, 16'h5555, 16'h0000, 5'd31, 1'b1, 16'h001F, 1'b0, CMP_GT);
    issue(OP_OR,  16'hF0F0, 16'h0F00, 5'd0, 1'b0, 16'hFFF0, 1'b0, CMP_GT);
    issue(OP_AND, 16'hF0F0, 16'h3C3C, 5'd0, 1'b0, 16'h3030, 1'b0, CMP_GT);
    issue(OP_NOT, 16'h00FF, 16'h1234, 5'd0, 1'b0, 16'hFF00, 1'b0, CMP_GT);
    issue(OP_LSL, 16'h0001, 16'd16, 5'd0, 1'b0, 16'h0000, 1'b0, CMP_GT);
    issue(OP_LSL, 16'h0001, 16'd15, 5'd0, 1'b0, 16'h8000, 1'b0, CMP_GT);
    issue(OP_LSL, 16'h0003, 16'd0, 5'd4, 1'b1, 16'h0030, 1'b0, CMP_GT);
    issue(OP_LSR, 16'h8000, 16'd15, 5'd0, 1'b0, 16'h0001, 1'b0, CMP_GT);
    issue(OP_LSR, 16'hFFFF, 16'd17, 5'd0, 1'b0, 16'h0000, 1'b0, CMP_GT);
    issue(4'd15, 16'hFFFF, 16'hFFFF, 5'd0, 1'b0, 16'h0000, 1'b1, CMP_GT);
`ifdef ALU_SIGNED_EN
    issue(OP_CMPS, 16'hFFFF, 16'h0001, 5'd0, 1'b0, 16'd0, 1'b0, CMP_LT);
    check("cmps_neg_lt_flag", 32'(bus.cmp_flag), 32'(CMP_LT));
    issue(OP_CMPS, 16'h0001, 16'hFFFF, 5'd0, 1'b0, 16'd0, 1'b0, CMP_GT);
    issue(OP_ASR, 16'h8000, 16'd4, 5'd0, 1'b0, 16'hF800, 1'b0, CMP_GT);
    issue(OP_ASR, 16'h8000, 16'd20, 5'd0, 1'b0, 16'hFFFF, 1'b0, CMP_GT);
    issue(OP_ASR, 16'h4000, 16'd0, 5'd2, 1'b1, 16'h1000, 1'b0, CMP_GT);
`else
    issue(4'd12, 16'hFFFF, 16'h0001, 5'd0, 1'b0, 16'd0, 1'b1, CMP_GT);
    issue(4'd13, 16'h8000, 16'd4, 5'd0, 1'b0, 16'd0, 1'b1, CMP_GT);
`endif
    check("cmp_flag_before_reset", 32'(bus.cmp_flag), 32'(CMP_GT));

    // asynchronous reset in the middle of a MUL
    issue(OP_MUL, 16'd3, 16'd3, 5'd0, 1'b0, 16'd9, 1'b0, CMP_GT, 1'b0);
    check("rstmul_busy_before", 32'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmul_out_valid", 32'(bus.out_valid), 0);
    check("rstmul_busy", 32'(bus.busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rstmul_no_result", 32'(bus.out_valid), 0);
    check("rstmul_result_cleared", 32'(bus.result), 0);
    check("rstmul_cmp_cleared", 32'(bus.cmp_flag), 0);
    issue(OP_ADD, 16'd5, 16'd0, 5'd3, 1'b1, 16'd8, 1'b0, CMP_LT);

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
